// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, constants and bit-period arithmetic
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, IFG} uart_state_t;
  localparam int UART_DATA_BITS = 8;
  function automatic int ticks_per_bit(input int clk_hz, input int baud);
    return baud > 0 ? clk_hz / baud : 0;
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: register-based synchronous FIFO with full/empty flags and level
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic do_push, do_pop;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level = wr_q - rd_q;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign pop_data = mem_q[rd_q[AW-1:0]];
  always_comb begin
    mem_d = mem_q;
    wr_d = wr_q + PW'(do_push);
    rd_d = rd_q + PW'(do_pop);
    if (do_push) mem_d[wr_q[AW-1:0]] = push_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1/8N2 UART transmitter
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 0,
  parameter int BAUD_RATE = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in_data,
  input  logic       byte_in_valid,
  output logic       byte_in_ready,
  output logic       bit_out,
  output logic       busy
);
  localparam int TPB = ticks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int TW = TPB > 2 ? $clog2(TPB) : 1;
  localparam int AW = FIFO_DEPTH > 2 ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = AW + 1;
  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_START = START;
  localparam logic [2:0] S_DATA = DATA;
  localparam logic [2:0] S_STOP = STOP;
  if (TPB < 2) begin : g_bad_tpb
    $error("uart_tx: CLK_FREQ_HZ/BAUD_RATE must give at least 2 ticks per bit");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end
  logic [2:0] state_q, state_d, idx_q, idx_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic stop_q, stop_d, bit_q, bit_d, busy_q, busy_d, ready_q, ready_d;
  logic push, pop, full, empty, tick_end, stop_end;
  logic [7:0] head;
  logic [LW-1:0] level;
  assign push = byte_in_valid && ready_q && !full;
  assign tick_end = tick_q == TW'(TPB - 1);
  assign stop_end = tick_end && stop_q == 1'(STOP_BITS - 1);
  assign pop = !empty && (state_q == S_IDLE || (state_q == S_STOP && stop_end));
  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .push_data(byte_in_data),
    .pop(pop),
    .pop_data(head),
    .full(full),
    .empty(empty),
    .level(level)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    stop_d = stop_q;
    shift_d = shift_q;
    bit_d = bit_q;
    tick_d = (state_q == S_IDLE || tick_end) ? '0 : tick_q + 1'b1;
    ready_d = (level + LW'(push) - LW'(pop)) != LW'(FIFO_DEPTH);
    busy_d = state_q != S_IDLE || !empty;
    case (state_q)
      S_IDLE: begin
        bit_d = 1'b1;
        if (pop) begin
          state_d = S_START;
          shift_d = head;
          bit_d = 1'b0;
        end
      end
      S_START: if (tick_end) begin
        state_d = S_DATA;
        idx_d = '0;
        bit_d = shift_q[0];
      end
      S_DATA: if (tick_end) begin
        if (idx_q == 3'd7) begin
          state_d = S_STOP;
          stop_d = 1'b0;
          bit_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
          shift_d = shift_q >> 1;
          bit_d = shift_q[1];
        end
      end
      S_STOP: if (tick_end) begin
        if (!stop_end) stop_d = stop_q + 1'b1;
        else if (pop) begin
          state_d = S_START;
          shift_d = head;
          bit_d = 1'b0;
        end else state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        bit_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      tick_q <= '0;
      stop_q <= 1'b0;
      shift_q <= '0;
      bit_q <= 1'b1;
      busy_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      tick_q <= tick_d;
      stop_q <= stop_d;
      shift_q <= shift_d;
      bit_q <= bit_d;
      busy_q <= busy_d;
      ready_q <= ready_d;
    end
  end
  assign byte_in_ready = ready_q;
  assign bit_out = bit_q;
  assign busy = busy_q;
endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-to-serial UART transmitter, 8N1 framing with optional second stop bit, for the debug console path. Accepts bytes on a valid/ready stream into a small internal FIFO and serialises them onto `bit_out` at `BAUD_RATE`. It is the transmit-side counterpart of `uart_rx` and uses the same bit-period arithmetic so both ends of the link agree on timing.

## Interface
- `CLK_FREQ_HZ`, 0: clock frequency in Hz. Must be set.
- `BAUD_RATE`, 0: line rate in bit/s. Must be set.
- `STOP_BITS`, 1: stop bits per frame. Legal values are 1 or 2.
- `FIFO_DEPTH`, 16: byte FIFO depth. Power of two, minimum 2.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `byte_in_data`  in  8  byte to transmit.
- `byte_in_valid`  in  1  `byte_in_data` is valid.
- `byte_in_ready`  out  1  FIFO can accept a byte. Reset 0.
- `bit_out`  out  1  serial line, idle high. Reset 1.
- `busy`  out  1  FIFO non-empty or frame in progress. Reset 0.

## Operation
- `TICKS_PER_BIT = floor(CLK_FREQ_HZ / BAUD_RATE)`. Elaboration fails if `TICKS_PER_BIT < 2`, if `STOP_BITS` is not 1 or 2, or if `FIFO_DEPTH` is not a power of two ≥ 2.
- Tick counter width is `$clog2(TICKS_PER_BIT)`. It counts 0..`TICKS_PER_BIT-1`, then wraps to 0 at each bit boundary.
- Bit index is 3 bits wide; a separate stop counter tracks stop bits.
- A push occurs on any edge where `byte_in_valid && byte_in_ready`.
- `byte_in_ready = !full`. No push is accepted while full, even if a pop occurs on the same edge.
- When non-empty and non-full, a simultaneous push and pop leaves the FIFO level unchanged.
- The FSM uses a registered state and registered `bit_out`:
  - IDLE: `bit_out`=1. If FIFO non-empty: pop, load shift register, go to START.
  - START: `bit_out`=0 for `TICKS_PER_BIT` cycles, then go to DATA with index 0.
  - DATA: `bit_out` = shift[0], LSB first. Shift right every `TICKS_PER_BIT` cycles. After the 8th bit, go to STOP.
  - STOP: `bit_out`=1 for `STOP_BITS*TICKS_PER_BIT` cycles.
    - On the last tick, if the FIFO is non-empty: pop, load, go directly to START, so frames are contiguous with no gap.
    - Otherwise go to IDLE.
- `busy` = (state != IDLE) || FIFO non-empty, registered.
- Reset mid-frame:
  - `bit_out` goes to 1 immediately (asynchronously).
  - FIFO is emptied and state returns to IDLE.
  - The partial frame is abandoned and the line stays high.
- `byte_in_ready` rises on the first `clk` edge after `rst_n` deassertion.

## Timing
- Push at edge E: FIFO is non-empty after E. The IDLE pop occurs at E+1, and `bit_out` falls to 0 after E+1.
- Each bit lasts exactly `TICKS_PER_BIT` cycles.
- Frame length is `(9+STOP_BITS)*TICKS_PER_BIT` cycles.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- Throughput: one byte per frame time. The FIFO absorbs bursts of up to `FIFO_DEPTH` bytes plus the byte currently in the shift register.
- `busy` falls 1 cycle after the FSM enters IDLE with the FIFO empty.

## Structure
- Shared package `uart_pkg`, used by both `uart_rx` and `uart_tx`:
  - `uart_state_t` enum: IDLE, START, DATA, STOP, IFG.
  - Function `ticks_per_bit(clk_hz, baud)`.
  - Constant `UART_DATA_BITS = 8`.
- Sub-module `uart_sync_fifo`: register-based, parameterised by width and depth.
  - Async active-low reset; push/pop interface; `full`/`empty` flags.
  - Pointers are `$clog2(DEPTH)+1` bits for full/empty disambiguation.
  - Portable, with no vendor macro.
- `uart_tx` contains the FSM, tick counter, shift register and output register.

## Test plan
All scenarios use `CLK_FREQ_HZ=1_000_000` and `BAUD_RATE=100_000` (10 ticks per bit) unless stated otherwise.
- Single byte 0xA5 → `bit_out` shows 0 for 10 cycles, then 1,0,1,0,0,1,0,1 (10 cycles each), then 1. Start falls 2 edges after the push; `busy` is low 1 cycle after the frame ends.
- Burst of 0x00, 0xFF, 0x55 pushed on consecutive cycles → three contiguous 100-cycle frames with no idle gap. `busy` stays high for 300 cycles plus the start latency.
- Push 18 bytes with `byte_in_valid` held high:
  - 16 bytes enter the FIFO and the 17th is accepted after the first pop.
  - `byte_in_ready` is low while full.
  - All 18 bytes are sent in order.
- `STOP_BITS=2`, send 0x3C → the stop high lasts 20 cycles and the frame lasts 110 cycles. The next queued byte starts immediately after.
- Assert `rst_n` low in DATA bit 4 of 0xC3 with 3 bytes queued:
  - `bit_out` goes to 1 asynchronously, `busy` goes to 0, and no further frames are sent.
  - After release, `byte_in_ready` is 1 on the first edge.
  - A new 0x81 is sent correctly.
- Loopback `bit_out` → `uart_rx.bit_in` with random bytes and random valid gaps → the received sequence equals the sent sequence.
